// File: rtl/alu_rr_sched.sv
// alu_rr_sched: round-robin scheduler that shares one combinational ALU
// between NREQ requesters. Each accepted op runs IDLE -> EXEC -> RESP.
// The ALU operands are held in registers, and the ALU flags are captured
// into a tagged response.
// Optional build macro ALU_RR_SCHED_STATS_EN adds per-requester grant counters.
module alu_rr_sched #(
  parameter int W    = 4,
  parameter int NREQ = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [NREQ*W-1:0]   req_a,
  input  logic [NREQ*W-1:0]   req_b,
  input  logic [NREQ*3-1:0]   req_op,
  output logic [W-1:0]        alu_a,
  output logic [W-1:0]        alu_b,
  output logic [2:0]          alu_ctrl,
  input  logic [W-1:0]        alu_res,
  input  logic                alu_car,
  input  logic                alu_of,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [1:0]          rsp_id,
  output logic [W-1:0]        rsp_res,
  output logic                rsp_car,
  output logic                rsp_of
`ifdef ALU_RR_SCHED_STATS_EN
  ,
  input  logic                stat_clr,
  output logic [NREQ*16-1:0]  stat_grants
`endif
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]      state_reg;
  logic [1:0]      last_reg;
  logic [1:0]      id_reg;
  logic [W-1:0]    a_reg;
  logic [W-1:0]    b_reg;
  logic [2:0]      op_reg;
  logic [1:0]      rsp_id_reg;
  logic [W-1:0]    rsp_res_reg;
  logic            rsp_car_reg;
  logic            rsp_of_reg;

  logic [NREQ-1:0] hi_mask;
  logic [NREQ-1:0] pick;
  logic [NREQ-1:0] grant_oh;
  logic [NREQ-1:0] odd_sel;
  logic [NREQ-1:0] hi_sel;
  logic [1:0]      grant_idx;
  logic            accept;

  logic [W-1:0][NREQ-1:0] a_t;
  logic [W-1:0][NREQ-1:0] b_t;
  logic [2:0][NREQ-1:0]   op_t;
  logic [W-1:0]           sel_a;
  logic [W-1:0]           sel_b;
  logic [2:0]             sel_op;

  genvar gi, gb;

  // Round-robin pick. Prefer the lowest valid index above the pointer.
  // Otherwise wrap to the lowest valid index overall.
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_req
      assign hi_mask[gi] = req_valid[gi] && (2'(gi) > last_reg);
      assign odd_sel[gi] = (gi % 2 == 1) ? grant_oh[gi] : 1'b0;
      assign hi_sel[gi]  = (gi >= 2)     ? grant_oh[gi] : 1'b0;
      assign req_ready[gi] = (state_reg == IDLE) && !rst && grant_oh[gi];
    end
  endgenerate

  assign pick      = (|hi_mask) ? hi_mask : req_valid;
  assign grant_oh  = pick & (~pick + NREQ'(1));
  assign grant_idx = {|hi_sel, |odd_sel};
  assign accept    = |req_ready;

  // AND-OR operand mux keyed by the one-hot grant, built bit by bit
  generate
    for (gb = 0; gb < W; gb++) begin : g_ab_bit
      for (gi = 0; gi < NREQ; gi++) begin : g_ab_req
        assign a_t[gb][gi] = grant_oh[gi] & req_a[gi*W+gb];
        assign b_t[gb][gi] = grant_oh[gi] & req_b[gi*W+gb];
      end
      assign sel_a[gb] = |a_t[gb];
      assign sel_b[gb] = |b_t[gb];
    end
    for (gb = 0; gb < 3; gb++) begin : g_op_bit
      for (gi = 0; gi < NREQ; gi++) begin : g_op_req
        assign op_t[gb][gi] = grant_oh[gi] & req_op[gi*3+gb];
      end
      assign sel_op[gb] = |op_t[gb];
    end
  endgenerate

  // Control FSM with the operand latch, pointer and response capture
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      last_reg    <= 2'(NREQ - 1);
      id_reg      <= 2'd0;
      a_reg       <= '0;
      b_reg       <= '0;
      op_reg      <= 3'd0;
      rsp_id_reg  <= 2'd0;
      rsp_res_reg <= '0;
      rsp_car_reg <= 1'b0;
      rsp_of_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            a_reg     <= sel_a;
            b_reg     <= sel_b;
            op_reg    <= sel_op;
            id_reg    <= grant_idx;
            last_reg  <= grant_idx;
            state_reg <= EXEC;
          end
        end
        EXEC: begin
          rsp_id_reg  <= id_reg;
          rsp_res_reg <= alu_res;
          rsp_car_reg <= alu_car;
          rsp_of_reg  <= alu_of;
          state_reg   <= RESP;
        end
        RESP: begin
          if (rsp_ready) state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign alu_a     = a_reg;
  assign alu_b     = b_reg;
  assign alu_ctrl  = op_reg;
  assign rsp_valid = (state_reg == RESP);
  assign rsp_id    = rsp_id_reg;
  assign rsp_res   = rsp_res_reg;
  assign rsp_car   = rsp_car_reg;
  assign rsp_of    = rsp_of_reg;

`ifdef ALU_RR_SCHED_STATS_EN
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_stat
      logic [15:0] cnt_reg;
      // Saturating per-requester grant counter; clear beats increment
      always_ff @(posedge clk) begin
        if (rst || stat_clr) begin
          cnt_reg <= 16'd0;
        end else if (req_ready[gi] && cnt_reg != 16'hFFFF) begin
          cnt_reg <= cnt_reg + 16'd1;
        end
      end
      assign stat_grants[gi*16 +: 16] = cnt_reg;
    end
  endgenerate
`endif

endmodule

// File: tb/tb_alu_rr_sched.sv
// tb_alu_rr_sched: directed plus random stimulus for alu_rr_sched
// (W=4, NREQ=2). A stub ALU is attached to the DUT. Every cycle is checked
// against a transaction-level model of grants and responses.
module tb_alu_rr_sched;
  logic       clk;
  logic       rst;
  logic [1:0] req_valid;
  logic [1:0] req_ready;
  logic [7:0] req_a;
  logic [7:0] req_b;
  logic [5:0] req_op;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [2:0] alu_ctrl;
  logic [3:0] alu_res;
  logic       alu_car;
  logic       alu_of;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [1:0] rsp_id;
  logic [3:0] rsp_res;
  logic       rsp_car;
  logic       rsp_of;
`ifdef ALU_RR_SCHED_STATS_EN
  logic        stat_clr;
  logic [31:0] stat_grants;
`endif

  int total = 0;
  int bad   = 0;

  // Transaction model state
  int         last_m = 1;
  bit         pend   = 0;
  int         age    = 0;
  logic [1:0] e_id;
  logic [3:0] e_a, e_b, e_res;
  logic [2:0] e_op;
  logic       e_car, e_of;
  int         ids[$];

  alu_rr_sched #(.W(4), .NREQ(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_res(alu_res), .alu_car(alu_car), .alu_of(alu_of),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_res(rsp_res), .rsp_car(rsp_car), .rsp_of(rsp_of)
`ifdef ALU_RR_SCHED_STATS_EN
    , .stat_clr(stat_clr), .stat_grants(stat_grants)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stub ALU; returns {car, of, res}
  function automatic logic [5:0] alu_fn(input logic [3:0] a, input logic [3:0] b,
                                        input logic [2:0] op);
    logic [4:0] s;
    logic [3:0] r;
    logic       c, o;
    s = 5'd0; r = 4'd0; c = 1'b0; o = 1'b0;
    case (op)
      3'd0: begin s = {1'b0, a} + {1'b0, b}; r = s[3:0]; c = s[4];
                  o = (a[3] == b[3]) && (s[3] != a[3]); end
      3'd1: begin s = {1'b0, a} - {1'b0, b}; r = s[3:0]; c = s[4];
                  o = (a[3] != b[3]) && (s[3] != a[3]); end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = ~a;
      3'd6: begin r = {a[2:0], 1'b0}; c = a[3]; end
      default: begin r = {1'b0, a[3:1]}; c = a[0]; end
    endcase
    return {c, o, r};
  endfunction

  assign {alu_car, alu_of, alu_res} = alu_fn(alu_a, alu_b, alu_ctrl);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Check one cycle against the model, advance the model across the next
  // rising edge, then wait for the following falling edge.
  // Inputs must be set before calling.
  task automatic step();
    int         win;
    logic [1:0] win_oh;
    #1;
    win = -1;
    for (int k = 1; k <= 2; k++) begin
      int i;
      i = (last_m + k) % 2;
      if (win < 0 && req_valid[i]) win = i;
    end
    win_oh = (win >= 0 && !pend && !rst) ? 2'(1 << win) : 2'b00;
    chk("req_ready", 32'(req_ready), 32'(win_oh));
    chk("rsp_valid", 32'(rsp_valid), 32'(pend && age >= 2));
    if (pend && age == 1) begin
      chk("alu_a", 32'(alu_a), 32'(e_a));
      chk("alu_b", 32'(alu_b), 32'(e_b));
      chk("alu_ctrl", 32'(alu_ctrl), 32'(e_op));
    end
    if (pend && age >= 2) begin
      chk("rsp_id", 32'(rsp_id), 32'(e_id));
      chk("rsp_res", 32'(rsp_res), 32'(e_res));
      chk("rsp_car", 32'(rsp_car), 32'(e_car));
      chk("rsp_of", 32'(rsp_of), 32'(e_of));
    end
    if (rst) begin
      pend   = 0;
      last_m = 1;
    end else begin
      if (pend && age >= 2 && rsp_ready) begin
        ids.push_back(int'(e_id));
        $display("rsp id=%0d a=%h b=%h op=%0d res=%h car=%b of=%b",
                 e_id, e_a, e_b, e_op, e_res, e_car, e_of);
        pend = 0;
      end else if (pend) begin
        age++;
      end
      if (win_oh != 2'b00) begin
        pend   = 1;
        age    = 1;
        last_m = win;
        e_id   = 2'(win);
        e_a    = (win == 0) ? req_a[3:0] : req_a[7:4];
        e_b    = (win == 0) ? req_b[3:0] : req_b[7:4];
        e_op   = (win == 0) ? req_op[2:0] : req_op[5:3];
        {e_car, e_of, e_res} = alu_fn(e_a, e_b, e_op);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    int exp_seq[4];
    exp_seq = '{0, 1, 0, 1};
    // Reset held two cycles while both requesters are valid
    rst = 1'b1; req_valid = 2'b11; rsp_ready = 1'b1;
    req_a = 8'h73; req_b = 8'h15; req_op = 6'b001_000;
`ifdef ALU_RR_SCHED_STATS_EN
    stat_clr = 1'b0;
`endif
    @(negedge clk);
    step();
    chk("rst_alu_a", 32'(alu_a), 32'h0);
    chk("rst_alu_b", 32'(alu_b), 32'h0);
    chk("rst_alu_ctrl", 32'(alu_ctrl), 32'h0);
    chk("rst_rsp_id", 32'(rsp_id), 32'h0);
    chk("rst_rsp_res", 32'(rsp_res), 32'h0);
    chk("rst_rsp_flags", 32'({rsp_car, rsp_of}), 32'h0);
    step();

    // Single op: requester 0, 3 + 5 -> 8, no carry, signed overflow
    rst = 1'b0;
    step();
    req_valid = 2'b00;
    step();
    chk("add_res", 32'(rsp_res), 32'h8);
    chk("add_car", 32'(rsp_car), 32'h0);
    chk("add_of", 32'(rsp_of), 32'h1);
    chk("add_id", 32'(rsp_id), 32'h0);
    step();
    step();

    // Backpressure: response held for 5 cycles, then a single handshake
    req_valid = 2'b01; req_a = 8'h9C; req_b = 8'h46; req_op = 6'b010_001;
    rsp_ready = 1'b0;
    step();
    req_valid = 2'b11;
    step();
    for (int i = 0; i < 5; i++) step();
    rsp_ready = 1'b1; req_valid = 2'b00;
    step();
    step();

    // Reset mid-EXEC: requester 1 op=001 a=2 b=3 is discarded
    req_valid = 2'b10; req_a = 8'h20; req_b = 8'h30; req_op = 6'b001_000;
    step();
    req_valid = 2'b00; rst = 1'b1;
    step();
    rst = 1'b0;

    // Contention: both valid, expect ids 0,1,0,1, three cycles apart
    ids.delete();
    req_valid = 2'b11; req_a = 8'h5A; req_b = 8'hC3; req_op = 6'b100_110;
    for (int i = 0; i < 12; i++) step();
    chk("rr_count", 32'(ids.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < ids.size()) chk("rr_seq", 32'(ids[i]), 32'(exp_seq[i]));
    end

    // Random traffic with occasional reset and backpressure
    for (int n = 0; n < 400; n++) begin
      req_valid = 2'($urandom);
      req_a     = 8'($urandom);
      req_b     = 8'($urandom);
      req_op    = 6'($urandom);
      rsp_ready = ($urandom_range(0, 9) < 7);
      rst       = ($urandom_range(0, 49) == 0);
      step();
    end
    rst = 1'b0; req_valid = 2'b00; rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) step();

`ifdef ALU_RR_SCHED_STATS_EN
    // Grant counters: three grants to requester 1, one to requester 0
    stat_clr = 1'b1;
    step();
    stat_clr = 1'b0;
    for (int g = 0; g < 4; g++) begin
      req_valid = (g == 3) ? 2'b01 : 2'b10;
      step();
      req_valid = 2'b00;
      step();
      step();
    end
    chk("stat_grants", stat_grants, {16'd3, 16'd1});
    stat_clr = 1'b1;
    step();
    stat_clr = 1'b0;
    chk("stat_clr", stat_grants, 32'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
